// File: rtl/ens0_layer2_outreg.sv
// Output register stage for layer-2 neuron LUTs of ensemble member 0.
// Tags each accepted vector with a sequence number and buffers it in a 2-entry skid buffer.
module ens0_layer2_outreg #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [1:0]            occupancy
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] main_data;
  logic [TAG_WIDTH-1:0]  main_tag;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [TAG_WIDTH-1:0]  skid_tag;
  logic [TAG_WIDTH-1:0]  tag_cnt;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Handshake decode: in_ready depends on the state register and rst only.
  assign in_ready  = (state != FULL) & ~rst;
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_tag   = main_tag;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath load selects.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Main/skid storage and sequence tag counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
      tag_cnt   <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_tag  <= tag_cnt;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_tag  <= tag_cnt;
      end
      if (accept) begin
        tag_cnt <= tag_cnt + TAG_WIDTH'(1);
      end
    end
  end

endmodule
